imm_const_sequencer: RTL and testbench

IMM_CONST_SEQUENCER -- requirements
Module: imm_const_sequencer

---
 rtl/imm_const_sequencer_pkg.sv | 27 ++
 rtl/imm_const_sequencer_if.sv | 24 ++
 rtl/imm_const_sequencer_chunk_pick.sv | 17 +
 rtl/imm_const_sequencer.sv | 105 ++++++++++
 tb/tb_imm_const_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/imm_const_sequencer_pkg.sv
// Shared processor control definitions for the immediate constant sequencer:
// state encoding, extender control codes and the chunk-mask helper.
package imm_const_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVZ = 2'd1,
    ST_MOVK = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  localparam logic [2:0] MOVZ_CTRL_DEF = 3'b111;
  localparam logic [2:0] IDLE_CTRL_DEF = 3'b000;

  localparam logic [63:0] HALFWORD_ONES = 64'h0000_0000_0000_FFFF;

  // Bit i set when halfword i of the value is nonzero and so needs a step.
  function automatic logic [3:0] chunk_mask(input logic [63:0] v);
    logic [3:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m[i] = (v[16*i +: 16] != 16'h0000);
    end
    return m;
  endfunction

endpackage

// File: rtl/imm_const_sequencer_if.sv
// Bundle of the request, extender and result signals around the sequencer.
// master = the surrounding pipeline/extender side, slave = the sequencer side.
interface imm_const_sequencer_if;
  logic        req_valid;
  logic [63:0] req_value;
  logic        req_ready;
  logic [2:0]  ext_ctrl;
  logic [25:0] ext_imm26;
  logic [63:0] ext_busimm;
  logic        out_valid;
  logic [63:0] out_value;
  logic        out_ready;
  logic [2:0]  steps;

  modport master (
    output req_valid, req_value, ext_busimm, out_ready,
    input  req_ready, ext_ctrl, ext_imm26, out_valid, out_value, steps
  );

  modport slave (
    input  req_valid, req_value, ext_busimm, out_ready,
    output req_ready, ext_ctrl, ext_imm26, out_valid, out_value, steps
  );
endinterface

// File: rtl/imm_const_sequencer_chunk_pick.sv
// Lowest-set-bit picker over the 4-bit halfword mask.
module imm_const_sequencer_chunk_pick (
  input  logic [3:0] mask,
  output logic [1:0] hw,
  output logic       any
);

  always_comb begin
    hw  = '0;
    any = |mask;
    if (mask[0])      hw = 2'd0;
    else if (mask[1]) hw = 2'd1;
    else if (mask[2]) hw = 2'd2;
    else if (mask[3]) hw = 2'd3;
  end

endmodule

// File: rtl/imm_const_sequencer.sv
// Builds a 64-bit constant as one MOVZ plus MOVK steps through an external
// immediate extender, one nonzero halfword per cycle, lowest halfword first.
module imm_const_sequencer
  import imm_const_sequencer_pkg::*;
#(
  parameter logic [2:0] MOVZ_CTRL = MOVZ_CTRL_DEF,
  parameter logic [2:0] IDLE_CTRL = IDLE_CTRL_DEF
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        req_valid,
  input  logic [63:0] req_value,
  output logic        req_ready,
  output logic [2:0]  ext_ctrl,
  output logic [25:0] ext_imm26,
  input  logic [63:0] ext_busimm,
  output logic        out_valid,
  output logic [63:0] out_value,
  input  logic        out_ready,
  output logic [2:0]  steps
);

  seq_state_e  state_q, state_d;
  logic [63:0] value_q, value_d;
  logic [3:0]  mask_q,  mask_d;
  logic [63:0] acc_q,   acc_d;
  logic [2:0]  steps_q, steps_d;

  logic [1:0]  pick_hw;
  logic        pick_any;
  logic [1:0]  hw;
  logic [5:0]  shamt;
  logic [15:0] chunk;

  imm_const_sequencer_chunk_pick u_chunk_pick (
    .mask (mask_q),
    .hw   (pick_hw),
    .any  (pick_any)
  );

  // An all-zero value still takes one MOVZ at halfword 0.
  assign hw    = pick_any ? pick_hw : 2'd0;
  assign shamt = {hw, 4'b0000};
  assign chunk = 16'(value_q >> shamt);

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    mask_d    = mask_q;
    acc_d     = acc_q;
    steps_d   = steps_q;
    ext_ctrl  = IDLE_CTRL;
    ext_imm26 = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          value_d = req_value;
          mask_d  = chunk_mask(req_value);
          steps_d = '0;
          state_d = ST_MOVZ;
        end
      end

      ST_MOVZ, ST_MOVK: begin
        ext_ctrl  = MOVZ_CTRL;
        ext_imm26 = {3'b000, hw, chunk, 5'b00000};
        // MOVK keeps earlier halfwords and replaces only the one being issued.
        if (state_q == ST_MOVZ) acc_d = ext_busimm;
        else                    acc_d = (acc_q & ~(HALFWORD_ONES << shamt)) | ext_busimm;
        mask_d  = mask_q & ~(4'b0001 << hw);
        steps_d = steps_q + 3'd1;
        state_d = (mask_d != 4'b0000) ? ST_MOVK : ST_DONE;
      end

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      mask_q  <= '0;
      acc_q   <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      steps_q <= steps_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_value = acc_q;
  assign steps     = steps_q;

endmodule

// File: tb/tb_imm_const_sequencer.sv
// Directed bench for imm_const_sequencer with a behavioural MOVZ extender and
// a queue of expected extender immediates per build.
module tb_imm_const_sequencer;
  import imm_const_sequencer_pkg::*;

  logic CLK = 1'b0;
  logic resetl;
  always #5 CLK = ~CLK;

  imm_const_sequencer_if bus ();

  // Extender model: MOVZ places imm26[20:5] at halfword imm26[22:21], zeros elsewhere.
  logic [63:0] ext_chunk;
  assign ext_chunk      = {48'h0, bus.ext_imm26[20:5]};
  assign bus.ext_busimm = (bus.ext_ctrl == MOVZ_CTRL_DEF)
                          ? (ext_chunk << (16 * bus.ext_imm26[22:21])) : 64'h0;

  imm_const_sequencer #(.MOVZ_CTRL(MOVZ_CTRL_DEF), .IDLE_CTRL(IDLE_CTRL_DEF)) dut (
    .CLK        (CLK),
    .resetl     (resetl),
    .req_valid  (bus.req_valid),
    .req_value  (bus.req_value),
    .req_ready  (bus.req_ready),
    .ext_ctrl   (bus.ext_ctrl),
    .ext_imm26  (bus.ext_imm26),
    .ext_busimm (bus.ext_busimm),
    .out_valid  (bus.out_valid),
    .out_value  (bus.out_value),
    .out_ready  (bus.out_ready),
    .steps      (bus.steps)
  );

  int checks = 0;
  int errors = 0;
  logic [25:0] imm_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input logic [63:0] v, output int n);
    logic [15:0] c;
    logic [1:0]  h;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      c = v[16*i +: 16];
      h = 2'(i);
      if (c != 16'h0) begin
        imm_q.push_back({3'b000, h, c, 5'b00000});
        n++;
      end
    end
    if (n == 0) begin
      imm_q.push_back(26'h0);
      n = 1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_ext_ctrl"},  64'(bus.ext_ctrl),  64'(IDLE_CTRL_DEF));
    check({tag, "_ext_imm26"}, 64'(bus.ext_imm26), 64'd0);
  endtask

  // Issue one request, follow its steps, then hold DONE for 'hold' cycles
  // (optionally poking req_valid) before the consumer accepts.
  task automatic build(input logic [63:0] v, input int hold, input bit poke);
    int  n;
    int  cyc;
    bit  seen;
    @(negedge CLK);
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    imm_q.delete();
    push_expected(v, n);
    bus.req_valid = 1'b1;
    bus.req_value = v;
    @(negedge CLK);
    bus.req_valid = 1'b0;
    bus.req_value = '0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= 8) begin
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      check("step_ext_ctrl", 64'(bus.ext_ctrl), 64'(MOVZ_CTRL_DEF));
      if (imm_q.size() == 0) check("extra_step", 64'(imm_q.size()), 64'd1);
      else                   check("ext_imm26", 64'(bus.ext_imm26), 64'(imm_q.pop_front()));
      check("req_ready_busy", 64'(bus.req_ready), 64'd0);
      @(negedge CLK);
      cyc++;
    end
    check("out_valid_timeout", 64'(seen), 64'd1);
    check("latency", 64'(cyc), 64'(n + 1));
    check("steps_missing", 64'(imm_q.size()), 64'd0);
    check("out_value", bus.out_value, v);
    check("steps", 64'(bus.steps), 64'(n));
    check("done_ext_ctrl", 64'(bus.ext_ctrl), 64'(IDLE_CTRL_DEF));
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 1'b0;
      if (poke) begin
        bus.req_valid = 1'b1;
        bus.req_value = ~v;
      end
      @(negedge CLK);
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("hold_out_value", bus.out_value, v);
      check("hold_req_ready", 64'(bus.req_ready), 64'd0);
      check("hold_steps", 64'(bus.steps), 64'(n));
    end
    bus.req_valid = 1'b0;
    bus.req_value = '0;
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    check_idle_outputs("after_accept");
  endtask

  initial begin
    logic [63:0] rv;
    logic [3:0]  keep;
    int          n;

    resetl        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_value = '0;
    bus.out_ready = 1'b0;
    #1;
    check_idle_outputs("reset");
    check("reset_steps", 64'(bus.steps), 64'd0);
    check("reset_out_value", bus.out_value, 64'd0);
    repeat (2) @(negedge CLK);
    resetl = 1'b1;

    build(64'h0, 0, 1'b0);
    build(64'h0000_1234_0000_0000, 0, 1'b0);
    build(64'hDEAD_BEEF_CAFE_F00D, 0, 1'b0);
    build(64'h8000_0000_0000_0000, 5, 1'b1);
    build(64'h0001_0000_0000_FFFF, 2, 1'b0);

    // Reset while the second step (a MOVK) of a three-step build is in flight.
    @(negedge CLK);
    imm_q.delete();
    push_expected(64'hFFFF_0000_FFFF_0001, n);
    bus.req_valid = 1'b1;
    bus.req_value = 64'hFFFF_0000_FFFF_0001;
    @(negedge CLK);
    bus.req_valid = 1'b0;
    check("rst_movz_imm", 64'(bus.ext_imm26), 64'(imm_q.pop_front()));
    @(negedge CLK);
    check("rst_movk_imm", 64'(bus.ext_imm26), 64'(imm_q.pop_front()));
    resetl = 1'b0;
    #1;
    check_idle_outputs("midbuild_reset");
    check("midbuild_reset_steps", 64'(bus.steps), 64'd0);
    check("midbuild_reset_acc", bus.out_value, 64'd0);
    imm_q.delete();
    @(negedge CLK);
    resetl = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("post_reset_no_valid", 64'(bus.out_valid), 64'd0);
    end
    build(64'hFFFF_0000_FFFF_0001, 1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      rv   = {$urandom, $urandom};
      keep = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) if (!keep[i]) rv[16*i +: 16] = 16'h0;
      build(rv, k % 3, k[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
